// File: rtl/dacx311_rx.sv
// DACx311 SPI slave receiver: oversamples sclk/ss/mosi on clk and decodes
// the 16-bit write frame (pd[1:0], data MSB-first, pad) into registered outputs.
module dacx311_rx #(
  parameter int BITS        = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sclk,
  input  logic            ss,
  input  logic            mosi,
  output logic [1:0]      pd,
  output logic [BITS-1:0] data,
  output logic            valid,
  output logic            err,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_live;
  logic                   r_sclk_d;
  logic [15:0]            r_shift;
  logic [4:0]             r_count;
  logic                   r_cap;
  logic [1:0]             r_pd;
  logic [BITS-1:0]        r_data;
  logic                   r_valid;
  logic                   r_err;
  logic                   r_busy;

  logic w_sclk_s;
  logic w_ss_s;
  logic w_mosi_s;
  logic w_live;
  logic w_fall;
  logic w_clr;
  logic w_shift_en;
  logic w_cap;
  logic w_abort;
  logic w_unused_shift;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_live   = r_live[SYNC_STAGES-1];
  assign w_fall   = ~w_sclk_s & r_sclk_d;
  // Pad bits below the data field are shifted through but never read.
  assign w_unused_shift = ^r_shift;

  // Synchronizer chains; r_live marks when the chain outputs hold real samples,
  // so a frame in flight at reset release cannot look like an idle bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '0;
      r_mosi_sync <= '0;
      r_live      <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_live      <= {r_live[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ARM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath controls; a 16th edge beats a simultaneous ss drop.
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_shift_en   = 1'b0;
    w_cap        = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_ARM: begin
        if (w_live && !w_ss_s) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_ARM;
        end
      end
      ST_IDLE: begin
        if (w_ss_s) begin
          w_next_state = ST_SHIFT;
          w_clr        = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_fall && (r_count == 5'd15)) begin
          w_shift_en   = 1'b1;
          w_cap        = 1'b1;
          w_next_state = w_ss_s ? ST_DONE : ST_IDLE;
        end else if (!w_ss_s) begin
          w_next_state = ST_IDLE;
          w_abort      = (r_count != 5'd0) || w_fall;
        end else if (w_fall) begin
          w_shift_en   = 1'b1;
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (!w_ss_s) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      default: begin
        w_next_state = ST_ARM;
      end
    endcase
  end

  // Shift/count datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= 16'd0;
      r_count <= 5'd0;
      r_cap   <= 1'b0;
      r_pd    <= 2'd0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cap   <= w_cap;
      r_valid <= r_cap;
      r_err   <= w_abort;
      r_busy  <= (w_next_state == ST_SHIFT);
      if (w_clr) begin
        r_shift <= 16'd0;
        r_count <= 5'd0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[14:0], w_mosi_s};
        r_count <= (r_count == 5'd16) ? 5'd16 : r_count + 5'd1;
      end else begin
        r_shift <= r_shift;
        r_count <= r_count;
      end
      if (r_cap) begin
        r_pd   <= r_shift[15:14];
        r_data <= r_shift[13 -: BITS];
      end else begin
        r_pd   <= r_pd;
        r_data <= r_data;
      end
    end
  end

  assign pd    = r_pd;
  assign data  = r_data;
  assign valid = r_valid;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule
